// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-interface controller: one CONVST / BUSY / readout frame per start pulse,
// streaming CH_NUM channel-tagged samples downstream. Every ADC-facing output is a flop.
module ad7606_ctrl #(
  parameter int CH_NUM         = 8,
  parameter int RESET_CYC      = 10,
  parameter int CONVST_LOW_CYC = 2,
  parameter int RD_LOW_CYC     = 2,
  parameter int RD_HIGH_CYC    = 2,
  parameter int BUSY_TIMEOUT   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ad_busy_i,
  input  logic [15:0] ad_data_i,
  output logic        ad_reset_o,
  output logic        ad_convst_o,
  output logic        ad_cs_n_o,
  output logic        ad_rd_n_o,
  output logic [15:0] data_o,
  output logic [2:0]  ch_o,
  output logic        data_vld_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int PH_MAX = (CONVST_LOW_CYC > RD_LOW_CYC)
                          ? ((CONVST_LOW_CYC > RD_HIGH_CYC) ? CONVST_LOW_CYC : RD_HIGH_CYC)
                          : ((RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC);
  localparam int RST_W  = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TMO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYC - 1);
  localparam logic [PH_W-1:0]  CV_LAST  = PH_W'(CONVST_LOW_CYC - 1);
  localparam logic [PH_W-1:0]  RL_LAST  = PH_W'(RD_LOW_CYC - 1);
  localparam logic [PH_W-1:0]  RH_LAST  = PH_W'(RD_HIGH_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [2:0]       CH_LAST  = 3'(CH_NUM - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CONVST, S_WAIT_BH, S_WAIT_BL, S_RD_LOW, S_RD_HIGH, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rstCnt_q, rstCnt_d;
  logic [PH_W-1:0]    phCnt_q, phCnt_d;
  logic [TMO_W-1:0]   tmoCnt_q, tmoCnt_d;
  logic [2:0]         chCnt_q, chCnt_d;
  logic               busyMeta_q, busySync_q;
  logic               adReset_q, adReset_d;
  logic               convst_q, convst_d;
  logic               csN_q, csN_d;
  logic               rdN_q, rdN_d;
  logic [15:0]        data_q, data_d;
  logic [2:0]         ch_q, ch_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  // BUSY is asynchronous to clk; only the second flop is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyMeta_q <= 1'b0;
      busySync_q <= 1'b0;
    end else begin
      busyMeta_q <= ad_busy_i;
      busySync_q <= busyMeta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      rstCnt_q  <= '0;
      phCnt_q   <= '0;
      tmoCnt_q  <= '0;
      chCnt_q   <= '0;
      adReset_q <= 1'b1;
      convst_q  <= 1'b1;
      csN_q     <= 1'b1;
      rdN_q     <= 1'b1;
      data_q    <= '0;
      ch_q      <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rstCnt_q  <= rstCnt_d;
      phCnt_q   <= phCnt_d;
      tmoCnt_q  <= tmoCnt_d;
      chCnt_q   <= chCnt_d;
      adReset_q <= adReset_d;
      convst_q  <= convst_d;
      csN_q     <= csN_d;
      rdN_q     <= rdN_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are decided for the state being entered, so the registered pins line up with it.
  always_comb begin
    state_d   = state_q;
    rstCnt_d  = rstCnt_q;
    phCnt_d   = phCnt_q;
    tmoCnt_d  = tmoCnt_q;
    chCnt_d   = chCnt_q;
    adReset_d = 1'b0;
    convst_d  = 1'b1;
    csN_d     = 1'b1;
    rdN_d     = 1'b1;
    data_d    = data_q;
    ch_d      = ch_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;

    case (state_q)
      S_INIT: begin
        if (rstCnt_q == RST_LAST) begin
          state_d = S_IDLE;
        end else begin
          rstCnt_d  = rstCnt_q + RST_W'(1);
          adReset_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_CONVST;
          phCnt_d  = '0;
          convst_d = 1'b0;
        end
      end
      S_CONVST: begin
        if (phCnt_q == CV_LAST) begin
          state_d  = S_WAIT_BH;
          tmoCnt_d = '0;
        end else begin
          phCnt_d  = phCnt_q + PH_W'(1);
          convst_d = 1'b0;
        end
      end
      S_WAIT_BH: begin
        if (tmoCnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q + TMO_W'(1);
          if (busySync_q) state_d = S_WAIT_BL;
        end
      end
      S_WAIT_BL: begin
        if (tmoCnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q + TMO_W'(1);
          if (!busySync_q) begin
            state_d = S_RD_LOW;
            chCnt_d = '0;
            phCnt_d = '0;
            csN_d   = 1'b0;
            rdN_d   = 1'b0;
          end
        end
      end
      S_RD_LOW: begin
        csN_d = 1'b0;
        if (phCnt_q == RL_LAST) begin
          data_d  = ad_data_i;
          ch_d    = chCnt_q;
          vld_d   = 1'b1;
          phCnt_d = '0;
          if (chCnt_q == CH_LAST) begin
            state_d = S_DONE;
            csN_d   = 1'b1;
          end else begin
            state_d = S_RD_HIGH;
          end
        end else begin
          phCnt_d = phCnt_q + PH_W'(1);
          rdN_d   = 1'b0;
        end
      end
      S_RD_HIGH: begin
        csN_d = 1'b0;
        if (phCnt_q == RH_LAST) begin
          state_d = S_RD_LOW;
          chCnt_d = chCnt_q + 3'd1;
          phCnt_d = '0;
          rdN_d   = 1'b0;
        end else begin
          phCnt_d = phCnt_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_INIT;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ad_reset_o   = adReset_q;
  assign ad_convst_o  = convst_q;
  assign ad_cs_n_o    = csN_q;
  assign ad_rd_n_o    = rdN_q;
  assign data_o       = data_q;
  assign ch_o         = ch_q;
  assign data_vld_o   = vld_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Bench for ad7606_ctrl: a behavioural AD7606 (BUSY and data bus) plus an event log that
// is checked against the expected frame shape derived from the controller parameters.
module tb_ad7606_ctrl;

  localparam int CH_NUM         = 8;
  localparam int RESET_CYC      = 10;
  localparam int CONVST_LOW_CYC = 2;
  localparam int RD_LOW_CYC     = 2;
  localparam int RD_HIGH_CYC    = 2;
  localparam int BUSY_TIMEOUT   = 500;
  // BUSY moves 3 ns after an edge: two synchroniser edges, then the registered RD_n on the third.
  localparam int SYNC_LAT       = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        ad_busy_i = 1'b0;
  logic [15:0] ad_data_i = 16'h0;

  logic        adReset0, convst0, csN0, rdN0, vld0, done0, busy0, tmo0;
  logic [15:0] data0;
  logic [2:0]  ch0;
  logic        adReset1, convst1, csN1, rdN1, vld1, done1, busy1, tmo1;
  logic [15:0] data1;
  logic [2:0]  ch1;

  always #5 clk = ~clk;

  ad7606_ctrl #(
    .CH_NUM(CH_NUM), .RESET_CYC(RESET_CYC), .CONVST_LOW_CYC(CONVST_LOW_CYC),
    .RD_LOW_CYC(RD_LOW_CYC), .RD_HIGH_CYC(RD_HIGH_CYC), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .ad_busy_i(ad_busy_i), .ad_data_i(ad_data_i),
    .ad_reset_o(adReset0), .ad_convst_o(convst0), .ad_cs_n_o(csN0), .ad_rd_n_o(rdN0),
    .data_o(data0), .ch_o(ch0), .data_vld_o(vld0), .frame_done_o(done0),
    .busy_o(busy0), .timeout_o(tmo0)
  );

  ad7606_ctrl #(
    .CH_NUM(1), .RESET_CYC(RESET_CYC), .CONVST_LOW_CYC(CONVST_LOW_CYC),
    .RD_LOW_CYC(1), .RD_HIGH_CYC(1), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ad_busy_i(ad_busy_i), .ad_data_i(ad_data_i),
    .ad_reset_o(adReset1), .ad_convst_o(convst1), .ad_cs_n_o(csN1), .ad_rd_n_o(rdN1),
    .data_o(data1), .ch_o(ch1), .data_vld_o(vld1), .frame_done_o(done1),
    .busy_o(busy1), .timeout_o(tmo1)
  );

  // The ADC model and the event log follow whichever controller sel points at.
  logic        sel = 1'b0;
  logic        mConvst, mCs, mRd, mVld, mDone, mTmo;
  logic [15:0] mData;
  logic [2:0]  mCh;
  assign mConvst = sel ? convst1 : convst0;
  assign mCs     = sel ? csN1    : csN0;
  assign mRd     = sel ? rdN1    : rdN0;
  assign mVld    = sel ? vld1    : vld0;
  assign mDone   = sel ? done1   : done0;
  assign mTmo    = sel ? tmo1    : tmo0;
  assign mData   = sel ? data1   : data0;
  assign mCh     = sel ? ch1     : ch0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          convstFallQ[$], convstRiseQ[$], rdFallQ[$], rdRiseQ[$];
  int          csFallQ[$], csRiseQ[$], vldCycQ[$], vldChQ[$], doneQ[$], tmoQ[$];
  logic [15:0] vldDataQ[$];
  logic [15:0] expDataQ[$];
  int          busyFallCyc = 0;
  int          checkCnt = 0;
  int          errCnt = 0;

  logic pConvst = 1'b1, pCs = 1'b1, pRd = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      if (pConvst && !mConvst) convstFallQ.push_back(cyc);
      if (!pConvst && mConvst) convstRiseQ.push_back(cyc);
      if (pRd && !mRd) rdFallQ.push_back(cyc);
      if (!pRd && mRd) rdRiseQ.push_back(cyc);
      if (pCs && !mCs) csFallQ.push_back(cyc);
      if (!pCs && mCs) csRiseQ.push_back(cyc);
      if (mVld) begin
        vldCycQ.push_back(cyc);
        vldDataQ.push_back(mData);
        vldChQ.push_back(int'(mCh));
      end
      if (mDone) doneQ.push_back(cyc);
      if (mTmo) tmoQ.push_back(cyc);
    end
    pConvst = mConvst;
    pCs     = mCs;
    pRd     = mRd;
  end

  // Behavioural ADC: BUSY pulse triggered by CONVST, fresh data word per RD_n low pulse.
  bit   busyArm = 1'b1;
  bit   busyEarly = 1'b0;
  bit   fixedData = 1'b0;
  int   busyDly = 3;
  int   busyLen = 100;
  logic aPrevConvst = 1'b1;
  always begin
    @(posedge clk);
    #3;
    if (busyArm && !rst && ((!busyEarly && !aPrevConvst && mConvst) ||
                            (busyEarly && aPrevConvst && !mConvst))) begin
      repeat (busyDly) begin @(posedge clk); #3; end
      ad_busy_i = 1'b1;
      repeat (busyLen) begin @(posedge clk); #3; end
      ad_busy_i = 1'b0;
      busyFallCyc = cyc;
    end
    aPrevConvst = mConvst;
  end

  logic        pRdD = 1'b1;
  logic [15:0] dataVal;
  always begin
    @(posedge clk);
    #3;
    if (!mRd && pRdD) begin
      dataVal = fixedData ? (16'h1000 + 16'(expDataQ.size())) : 16'($urandom);
      ad_data_i = dataVal;
      expDataQ.push_back(dataVal);
    end else if (mRd) begin
      ad_data_i = 16'($urandom);
    end
    pRdD = mRd;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clearLog();
    convstFallQ.delete(); convstRiseQ.delete(); rdFallQ.delete(); rdRiseQ.delete();
    csFallQ.delete(); csRiseQ.delete(); vldCycQ.delete(); vldChQ.delete();
    vldDataQ.delete(); doneQ.delete(); tmoQ.delete(); expDataQ.delete();
  endtask

  task automatic setStart(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Pulse start and wait (bounded) for frame_done or timeout; optionally fire stray starts.
  task automatic applyStimulus(input bit injectExtra, output bit ended);
    int busyHigh;
    bit injRd;
    clearLog();
    setStart(1'b1);
    tick(1);
    setStart(1'b0);
    ended = 1'b0;
    busyHigh = 0;
    injRd = 1'b0;
    for (int n = 0; n < 2000 && !ended; n++) begin
      tick(1);
      setStart(1'b0);
      ended = (doneQ.size() > 0) || (tmoQ.size() > 0);
      if (ad_busy_i) busyHigh++;
      if (!ended && injectExtra && ad_busy_i && busyHigh == 8) setStart(1'b1);
      if (!ended && injectExtra && !injRd && !mRd && rdFallQ.size() == 4) begin
        setStart(1'b1);
        injRd = 1'b1;
      end
    end
    checkOutput("frame_end_seen", ended, 1);
  endtask

  task automatic checkFrame(input int n, input int rl, input int rh);
    checkOutput("convst_fall_cnt", convstFallQ.size(), 1);
    checkOutput("convst_rise_cnt", convstRiseQ.size(), 1);
    if (convstFallQ.size() == 1 && convstRiseQ.size() == 1)
      checkOutput("convst_low_width", convstRiseQ[0] - convstFallQ[0], CONVST_LOW_CYC);
    checkOutput("rd_fall_cnt", rdFallQ.size(), n);
    checkOutput("rd_rise_cnt", rdRiseQ.size(), n);
    if (rdFallQ.size() == n && rdRiseQ.size() == n) begin
      checkOutput("busy_fall_to_rd", rdFallQ[0] - busyFallCyc, SYNC_LAT);
      for (int i = 0; i < n; i++) begin
        checkOutput("rd_low_width", rdRiseQ[i] - rdFallQ[i], rl);
        if (i > 0) checkOutput("rd_high_gap", rdFallQ[i] - rdRiseQ[i-1], rh);
      end
      checkOutput("cs_fall_cnt", csFallQ.size(), 1);
      checkOutput("cs_rise_cnt", csRiseQ.size(), 1);
      if (csFallQ.size() == 1 && csRiseQ.size() == 1) begin
        checkOutput("cs_fall_at_rd", csFallQ[0], rdFallQ[0]);
        checkOutput("cs_rise_at_last_rd", csRiseQ[0], rdRiseQ[n-1]);
      end
      if (doneQ.size() == 1)
        checkOutput("readout_length", doneQ[0] - rdFallQ[0], n * rl + (n - 1) * rh + 1);
    end
    checkOutput("vld_cnt", vldCycQ.size(), n);
    for (int i = 0; i < n && i < vldCycQ.size(); i++) begin
      checkOutput("vld_ch", vldChQ[i], i);
      if (i < expDataQ.size()) checkOutput("vld_data", vldDataQ[i], expDataQ[i]);
      else                     checkOutput("adc_word_driven", expDataQ.size(), i + 1);
      if (i < rdRiseQ.size()) checkOutput("vld_at_rd_rise", vldCycQ[i], rdRiseQ[i]);
    end
    checkOutput("done_cnt", doneQ.size(), 1);
    if (doneQ.size() == 1 && vldCycQ.size() > 0)
      checkOutput("done_after_last_vld", doneQ[0], vldCycQ[vldCycQ.size()-1] + 1);
    checkOutput("timeout_cnt", tmoQ.size(), 0);
  endtask

  // Releases reset and measures how many edges the ADC reset stays asserted.
  task automatic releaseReset();
    int   n;
    logic busyPrev;
    rst = 1'b0;
    n = 0;
    busyPrev = busy0;
    do begin
      busyPrev = busy0;
      tick(1);
      n++;
    end while (adReset0 && n < 50);
    checkOutput("ad_reset_width", n, RESET_CYC);
    checkOutput("busy_during_init", busyPrev, 1);
    checkOutput("busy_after_init", busy0, 0);
    checkOutput("dut1_ad_reset_low", adReset1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ended;
    int n;

    $display("[TB] reset values");
    tick(3);
    checkOutput("rst_ad_reset", adReset0, 1);
    checkOutput("rst_convst", convst0, 1);
    checkOutput("rst_cs_n", csN0, 1);
    checkOutput("rst_rd_n", rdN0, 1);
    checkOutput("rst_data", data0, 0);
    checkOutput("rst_ch", ch0, 0);
    checkOutput("rst_vld", vld0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_timeout", tmo0, 0);
    checkOutput("rst_busy", busy0, 1);
    releaseReset();
    checkOutput("idle_convst", convst0, 1);
    checkOutput("idle_cs_n", csN0, 1);
    checkOutput("idle_rd_n", rdN0, 1);

    $display("[TB] directed frame");
    fixedData = 1'b1;
    busyDly = 3;
    busyLen = 100;
    applyStimulus(1'b0, ended);
    checkFrame(CH_NUM, RD_LOW_CYC, RD_HIGH_CYC);
    for (int i = 0; i < vldDataQ.size(); i++)
      checkOutput("directed_data", vldDataQ[i], 32'h1000 + i);
    fixedData = 1'b0;

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      busyDly = $urandom_range(0, 10);
      busyLen = $urandom_range(2, 150);
      tick($urandom_range(1, 5));
      applyStimulus(1'b0, ended);
      checkFrame(CH_NUM, RD_LOW_CYC, RD_HIGH_CYC);
    end

    $display("[TB] BUSY already high at WAIT_BH entry");
    busyEarly = 1'b1;
    busyDly = 0;
    busyLen = 40;
    tick(3);
    applyStimulus(1'b0, ended);
    checkFrame(CH_NUM, RD_LOW_CYC, RD_HIGH_CYC);
    busyEarly = 1'b0;

    $display("[TB] BUSY never asserts");
    busyArm = 1'b0;
    tick(3);
    applyStimulus(1'b0, ended);
    checkOutput("tmo_cnt", tmoQ.size(), 1);
    if (tmoQ.size() == 1 && convstRiseQ.size() == 1)
      checkOutput("tmo_delay", tmoQ[0] - convstRiseQ[0], BUSY_TIMEOUT);
    checkOutput("tmo_no_rd", rdFallQ.size(), 0);
    checkOutput("tmo_no_cs", csFallQ.size(), 0);
    checkOutput("tmo_no_vld", vldCycQ.size(), 0);
    checkOutput("tmo_no_done", doneQ.size(), 0);
    tick(1);
    checkOutput("tmo_back_idle", busy0, 0);
    checkOutput("tmo_single_pulse", tmo0, 0);
    busyArm = 1'b1;

    $display("[TB] stray starts then back-to-back frame");
    busyDly = 3;
    busyLen = 60;
    tick(2);
    applyStimulus(1'b1, ended);
    checkFrame(CH_NUM, RD_LOW_CYC, RD_HIGH_CYC);
    checkOutput("no_queued_start", busy0, 0);
    applyStimulus(1'b0, ended);
    checkFrame(CH_NUM, RD_LOW_CYC, RD_HIGH_CYC);

    $display("[TB] reset during channel 4 readout");
    busyLen = 30;
    tick(2);
    clearLog();
    setStart(1'b1);
    tick(1);
    setStart(1'b0);
    n = 0;
    while (!(vldChQ.size() == 4 && !mRd) && n < 2000) begin
      tick(1);
      n++;
    end
    checkOutput("reached_ch4", n < 2000, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rd_n", rdN0, 1);
    checkOutput("mid_rst_cs_n", csN0, 1);
    checkOutput("mid_rst_vld", vld0, 0);
    checkOutput("mid_rst_ad_reset", adReset0, 1);
    checkOutput("mid_rst_busy", busy0, 1);
    checkOutput("mid_rst_data", data0, 0);
    tick(2);
    clearLog();
    releaseReset();
    tick(20);
    checkOutput("post_rst_no_vld", vldCycQ.size(), 0);
    checkOutput("post_rst_no_done", doneQ.size(), 0);
    checkOutput("post_rst_no_rd", rdFallQ.size(), 0);
    checkOutput("post_rst_no_convst", convstFallQ.size(), 0);

    $display("[TB] single-channel controller");
    sel = 1'b1;
    busyDly = 3;
    busyLen = 20;
    tick(2);
    applyStimulus(1'b0, ended);
    checkFrame(1, 1, 1);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/ad7606_ctrl.md
Name: ad7606_ctrl

Overview:
- Consumes the periodic 1-cycle sample-enable pulse from the enable generator and runs one complete AD7606 conversion/readout frame per pulse.
- Drives the ADC parallel interface (CONVST, CS_n, RD_n, RESET) and monitors BUSY.
- Presents CH_NUM 16-bit results, one per cycle-pulse with a channel index, to the downstream capture/packing logic.

Parameters:
- CH_NUM, 8, channels read per frame (1..8).
- RESET_CYC, 10, AD_RESET high width after reset release, in clk cycles (min 1).
- CONVST_LOW_CYC, 2, CONVST low width in cycles (min 1).
- RD_LOW_CYC, 2, RD_n low width per channel (min 1).
- RD_HIGH_CYC, 2, RD_n high gap between channels (min 1).
- BUSY_TIMEOUT, 500, max cycles from CONVST rising edge to BUSY falling edge.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  1-cycle frame request (sample-enable pulse).
- ad_busy_i  in  1  ADC BUSY, asynchronous to clk.
- ad_data_i  in  16  ADC parallel data bus.
- ad_reset_o  out  1  ADC RESET, active-high.
- ad_convst_o  out  1  ADC CONVST (A and B tied), idle high.
- ad_cs_n_o  out  1  ADC chip select, active-low.
- ad_rd_n_o  out  1  ADC read strobe, active-low.
- data_o  out  16  captured sample.
- ch_o  out  3  channel index of data_o (0..CH_NUM-1).
- data_vld_o  out  1  1-cycle strobe; data_o/ch_o valid.
- frame_done_o  out  1  1-cycle strobe after the last channel is output.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- timeout_o  out  1  1-cycle strobe on BUSY timeout.

Behaviour:
- Reset (async assert, sync deassert inside clk domain): state=INIT, ad_reset_o=1, ad_convst_o=1, ad_cs_n_o=1, ad_rd_n_o=1, data_o=0, ch_o=0, data_vld_o=0, frame_done_o=0, timeout_o=0, busy_o=1, all counters 0.
- BUSY path: ad_busy_i passes through a 2-flop synchronizer. Only the synced copy is used, so BUSY edges are seen 2-3 cycles late.
- All ADC outputs are registered. There is no combinational path from inputs to outputs.
- FSM states and transitions:
  - INIT: ad_reset_o=1 for RESET_CYC cycles, then IDLE with ad_reset_o=0.
  - IDLE: busy_o=0. start_i=1 -> CONVST.
  - CONVST: ad_convst_o=0 for CONVST_LOW_CYC cycles, then high -> WAIT_BH. The timeout counter starts from 0 here.
  - WAIT_BH: wait for synced BUSY=1 -> WAIT_BL.
  - WAIT_BL: wait for synced BUSY=0 -> RD_LOW with ch=0.
  - Timeout: the counter runs across WAIT_BH and WAIT_BL. Reaching BUSY_TIMEOUT-1 pulses timeout_o for 1 cycle and goes to IDLE. No data is read and frame_done_o stays 0.
  - RD_LOW: ad_cs_n_o=0, ad_rd_n_o=0 for RD_LOW_CYC cycles.
    - On the last low cycle, register ad_data_i into data_o and set ch_o=ch.
    - data_vld_o is high the following cycle, coincident with ad_rd_n_o rising.
    - If ch==CH_NUM-1, go to DONE; else go to RD_HIGH.
  - RD_HIGH: ad_rd_n_o=1 and ad_cs_n_o=0 for RD_HIGH_CYC cycles, then ch+1 -> RD_LOW.
  - DONE: ad_cs_n_o=1 and frame_done_o=1 for one cycle (the cycle after the last data_vld_o) -> IDLE.
- start_i outside IDLE (including INIT) is ignored, not queued. The frame rate is set by the upstream interval, which must be at least the frame length.
- start_i on the same cycle DONE->IDLE is ignored; the FSM enters IDLE on the next cycle.
- BUSY already high when entering WAIT_BH: advance on the first cycle.
- ch counter: 3 bits, CH_NUM=8 ends at 7 without overflow use.
- Counters: widths sized by $clog2 of each parameter, minimum 1 bit.
- Reset mid-frame: all outputs return to reset values immediately. INIT runs again, so the ADC is re-reset.
- Nominal frame length (no timeout), in cycles: CONVST_LOW_CYC + BUSY latency + CH_NUM*RD_LOW_CYC + (CH_NUM-1)*RD_HIGH_CYC + 1 + synchronizer delays.

Test Plan:
- Reset release with defaults -> ad_reset_o high exactly 10 cycles, then low. busy_o falls the same cycle. CONVST/CS_n/RD_n stay high.
- start_i pulse; BUSY model high 3 cycles after CONVST rising and low 100 cycles later; ad_data_i = 0x1000+ch during each RD low.
  - Required: CONVST low 2 cycles.
  - 8 RD_n low pulses of 2 cycles with 2-cycle gaps, CS_n low continuously across them.
  - data_vld_o 8 times with data_o 0x1000..0x1007 and ch_o 0..7.
  - frame_done_o 1 cycle after the 8th strobe.
- BUSY never asserts -> timeout_o pulses once 500 cycles after CONVST rising. No RD_n activity, no frame_done_o, FSM back in IDLE.
- Extra start_i pulses during WAIT_BL and RD_LOW -> ignored. Exactly 8 data_vld_o. A start_i 1 cycle after frame_done_o starts a new frame.
- rst asserted during channel 4 RD_LOW -> RD_n/CS_n high asynchronously and data_vld_o=0. ad_reset_o is high for 10 cycles after release with no residual strobes.
- CH_NUM=1, RD_LOW_CYC=1, RD_HIGH_CYC=1 -> single RD_n pulse of 1 cycle, one data_vld_o with ch_o=0, frame_done_o on the next cycle.
